// File: rtl/rob_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_if : dispatch, FU completion and retire signals of the ROB        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface rob_if #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              alloc_valid_1, alloc_valid_2;
  logic [PREG_W-1:0] alloc_preg_1, alloc_preg_2;
  logic [PREG_W-1:0] alloc_old_preg_1, alloc_old_preg_2;
  logic              alloc_store_1, alloc_store_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;
  logic              comp_valid_1, comp_valid_2, comp_valid_3;
  logic [IDX_W-1:0]  comp_idx_1, comp_idx_2, comp_idx_3;
  logic              comp_err;
  logic              rt_flag_1, rt_flag_2;
  logic [PREG_W-1:0] rt_preg_1, rt_preg_2, rt_old_preg_1, rt_old_preg_2;
  logic              rt_store_1, rt_store_2;
  logic [CNT_W-1:0]  count;
  logic              empty, full;
  logic [31:0]       retired_count;

  modport master (
    output flush, alloc_valid_1, alloc_valid_2, alloc_preg_1, alloc_preg_2,
           alloc_old_preg_1, alloc_old_preg_2, alloc_store_1, alloc_store_2,
           comp_valid_1, comp_valid_2, comp_valid_3, comp_idx_1, comp_idx_2, comp_idx_3,
    input  alloc_ready, alloc_idx_1, alloc_idx_2, comp_err, rt_flag_1, rt_flag_2,
           rt_preg_1, rt_preg_2, rt_old_preg_1, rt_old_preg_2, rt_store_1, rt_store_2,
           count, empty, full, retired_count
  );

  modport slave (
    input  flush, alloc_valid_1, alloc_valid_2, alloc_preg_1, alloc_preg_2,
           alloc_old_preg_1, alloc_old_preg_2, alloc_store_1, alloc_store_2,
           comp_valid_1, comp_valid_2, comp_valid_3, comp_idx_1, comp_idx_2, comp_idx_3,
    output alloc_ready, alloc_idx_1, alloc_idx_2, comp_err, rt_flag_1, rt_flag_2,
           rt_preg_1, rt_preg_2, rt_old_preg_1, rt_old_preg_2, rt_store_1, rt_store_2,
           count, empty, full, retired_count
  );
endinterface
`default_nettype wire

// File: rtl/rob_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ctrl : circular reorder buffer, 2-wide alloc, 3 completions,      |
// |            2-wide in-order retire                                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rob_ctrl #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  rob_if.slave bus
);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  r_v, r_comp, r_store;
  logic [PREG_W-1:0] r_preg     [DEPTH];
  logic [PREG_W-1:0] r_old_preg [DEPTH];
  logic [IDX_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [IDX_W-1:0]  w_head_1, w_tail_1;
  logic              w_ready, w_alloc_1, w_alloc_2, w_rt_1, w_rt_2, w_err;
  logic [CNT_W-1:0]  w_n_alloc, w_n_ret;
  logic [2:0]        w_cv;
  logic [IDX_W-1:0]  w_ci [3];

  assign w_head_1  = r_head + 1'b1;
  assign w_tail_1  = r_tail + 1'b1;
  assign w_ready   = (r_count <= CNT_W'(DEPTH - 2));
  assign w_alloc_1 = w_ready & bus.alloc_valid_1;
  assign w_alloc_2 = w_alloc_1 & bus.alloc_valid_2;
  // Retire looks only at registered state, so a same-cycle completion waits a cycle
  assign w_rt_1    = r_v[r_head] & r_comp[r_head];
  assign w_rt_2    = w_rt_1 & r_v[w_head_1] & r_comp[w_head_1];
  assign w_n_alloc = CNT_W'(w_alloc_1) + CNT_W'(w_alloc_2);
  assign w_n_ret   = CNT_W'(w_rt_1) + CNT_W'(w_rt_2);

  assign w_cv    = {bus.comp_valid_3, bus.comp_valid_2, bus.comp_valid_1};
  assign w_ci[0] = bus.comp_idx_1;
  assign w_ci[1] = bus.comp_idx_2;
  assign w_ci[2] = bus.comp_idx_3;

  always_comb begin
    w_err = 1'b0;
    for (int k = 0; k < 3; k++)
      if (w_cv[k] && !r_v[w_ci[k]]) w_err = 1'b1;
  end

  assign bus.alloc_ready = w_ready;
  assign bus.alloc_idx_1 = r_tail;
  assign bus.alloc_idx_2 = w_tail_1;
  assign bus.count       = r_count;
  assign bus.empty       = (r_count == '0);
  assign bus.full        = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_comp <= '0;
      r_store <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_preg[i]     <= '0;
        r_old_preg[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      bus.retired_count <= '0;
      bus.comp_err  <= 1'b0;
      bus.rt_flag_1 <= 1'b0;
      bus.rt_flag_2 <= 1'b0;
      bus.rt_preg_1 <= '0;
      bus.rt_preg_2 <= '0;
      bus.rt_old_preg_1 <= '0;
      bus.rt_old_preg_2 <= '0;
      bus.rt_store_1 <= 1'b0;
      bus.rt_store_2 <= 1'b0;
    end else if (bus.flush) begin
      r_v     <= '0;
      r_comp  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      bus.comp_err  <= 1'b0;
      bus.rt_flag_1 <= 1'b0;
      bus.rt_flag_2 <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (w_cv[k] && r_v[w_ci[k]]) r_comp[w_ci[k]] <= 1'b1;
      // Retired and allocated entries never overlap, so ordering here is safe
      if (w_rt_1) begin
        r_v[r_head]    <= 1'b0;
        r_comp[r_head] <= 1'b0;
      end
      if (w_rt_2) begin
        r_v[w_head_1]    <= 1'b0;
        r_comp[w_head_1] <= 1'b0;
      end
      if (w_alloc_1) begin
        r_v[r_tail]        <= 1'b1;
        r_comp[r_tail]     <= 1'b0;
        r_store[r_tail]    <= bus.alloc_store_1;
        r_preg[r_tail]     <= bus.alloc_preg_1;
        r_old_preg[r_tail] <= bus.alloc_old_preg_1;
      end
      if (w_alloc_2) begin
        r_v[w_tail_1]        <= 1'b1;
        r_comp[w_tail_1]     <= 1'b0;
        r_store[w_tail_1]    <= bus.alloc_store_2;
        r_preg[w_tail_1]     <= bus.alloc_preg_2;
        r_old_preg[w_tail_1] <= bus.alloc_old_preg_2;
      end
      r_head  <= r_head + w_n_ret[IDX_W-1:0];
      r_tail  <= r_tail + w_n_alloc[IDX_W-1:0];
      r_count <= r_count + w_n_alloc - w_n_ret;
      bus.retired_count <= bus.retired_count + 32'(w_n_ret);
      bus.comp_err  <= w_err;
      bus.rt_flag_1 <= w_rt_1;
      bus.rt_flag_2 <= w_rt_2;
      if (w_rt_1) begin
        bus.rt_preg_1     <= r_preg[r_head];
        bus.rt_old_preg_1 <= r_old_preg[r_head];
        bus.rt_store_1    <= r_store[r_head];
      end
      if (w_rt_2) begin
        bus.rt_preg_2     <= r_preg[w_head_1];
        bus.rt_old_preg_2 <= r_old_preg[w_head_1];
        bus.rt_store_2    <= r_store[w_head_1];
      end
    end
  end
endmodule
`default_nettype wire
